// File: rtl/dm_dmi_bus_bridge_pkg.sv
// rtl/dm_dmi_bus_bridge_pkg.sv - DMI request/response types shared by the bridge and its users
package dm_dmi_bus_bridge_pkg;

  // Bus byte-address bit where the DMI register index starts
  localparam int DmiAddrLsb   = 2;
  localparam int DmiAddrWidth = 7;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  typedef struct packed {
    logic [DmiAddrWidth-1:0] addr;
    dtm_op_e                 op;
    logic [31:0]             data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

endpackage

// File: rtl/dm_dmi_bus_bridge_if.sv
// rtl/dm_dmi_bus_bridge_if.sv - host-side memory-mapped bus into the DMI bridge
interface dm_dmi_bus_bridge_if #(
  parameter int BusWidth = 32
);
  logic                  req;
  logic                  we;
  logic [BusWidth-1:0]   addr;
  logic [BusWidth-1:0]   wdata;
  logic [BusWidth/8-1:0] be;
  logic                  gnt;
  logic                  rvalid;
  logic [BusWidth-1:0]   rdata;
  logic                  err;

  modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dm_dmi_bus_bridge.sv
// rtl/dm_dmi_bus_bridge.sv - memory-mapped bus to DMI master with response timeout and stale-response drain
module dm_dmi_bus_bridge
  import dm_dmi_bus_bridge_pkg::*;
#(
  parameter int BusWidth      = 32,
  parameter int TimeoutCycles = 1024
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  dm_dmi_bus_bridge_if.slave bus,
  output logic      dmi_req_valid_o,
  input  logic      dmi_req_ready_i,
  output dmi_req_t  dmi_req_o,
  input  logic      dmi_resp_valid_i,
  output logic      dmi_resp_ready_o,
  input  dmi_resp_t dmi_resp_i
);

  localparam int TimerWidth = $clog2(TimeoutCycles + 1);
  localparam int NumLanes   = BusWidth / 32;
  localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TimeoutCycles - 1);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp,
    StRet
  } state_e;

  state_e                state_q, state_d;
  dmi_req_t              req_q, req_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  drain_q, drain_d;
  logic [TimerWidth-1:0] timer_q, timer_d;

  logic [31:0] lane_wdata;
  logic [3:0]  lane_be;
  logic        unused_addr;

  assign unused_addr = ^{bus.addr[BusWidth-1:9], bus.addr[DmiAddrLsb-1:0]};

  // Pick the 32-bit write lane and its byte enables; a 64-bit bus selects by addr[2]
  always_comb begin
    lane_wdata = bus.wdata[31:0];
    lane_be    = bus.be[3:0];
    if ((BusWidth == 64) && bus.addr[2]) begin
      lane_wdata = bus.wdata[BusWidth-1 -: 32];
      lane_be    = bus.be[BusWidth/8-1 -: 4];
    end
  end

  // Next-state and handshake outputs; a response arriving while draining is always swallowed
  always_comb begin
    state_d          = state_q;
    req_d            = req_q;
    rdata_d          = rdata_q;
    err_d            = err_q;
    drain_d          = drain_q;
    timer_d          = timer_q;
    bus.gnt          = 1'b0;
    dmi_req_valid_o  = 1'b0;
    dmi_resp_ready_o = drain_q;

    if (drain_q && dmi_resp_valid_i) begin
      drain_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        bus.gnt = bus.req;
        if (bus.req) begin
          req_d.addr = bus.addr[DmiAddrLsb +: DmiAddrWidth];
          req_d.op   = bus.we ? DTM_WRITE : DTM_READ;
          req_d.data = bus.we ? lane_wdata : 32'h0;
          // Partial-word writes cannot be expressed on DMI, so fail them locally
          if (bus.we && (lane_be != 4'hF)) begin
            err_d   = 1'b1;
            rdata_d = 32'h0;
            state_d = StRet;
          end else begin
            err_d   = 1'b0;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        dmi_req_valid_o = 1'b1;
        if (dmi_req_ready_i) begin
          timer_d = '0;
          state_d = StResp;
        end
      end
      StResp: begin
        dmi_resp_ready_o = 1'b1;
        timer_d          = timer_q + TimerWidth'(1);
        if (dmi_resp_valid_i && !drain_q) begin
          rdata_d = dmi_resp_i.data;
          err_d   = (dmi_resp_i.resp != 2'b00);
          state_d = StRet;
        end else if (timer_q == TimerLast) begin
          // The DM may still answer later; that answer must not be taken as the next access's
          err_d   = 1'b1;
          rdata_d = 32'h0;
          drain_d = 1'b1;
          state_d = StRet;
        end
      end
      StRet: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.rvalid = (state_q == StRet);
  assign bus.err    = (state_q == StRet) && err_q;
  assign bus.rdata  = ((state_q == StRet) && !err_q) ? {NumLanes{rdata_q}} : '0;
  assign dmi_req_o  = (state_q == StReq) ? req_q : '0;

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      drain_q <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      drain_q <= drain_d;
      timer_q <= timer_d;
    end
  end

endmodule

// File: tb/tb_dm_dmi_bus_bridge.sv
// tb/tb_dm_dmi_bus_bridge.sv - directed self-checking bench for dm_dmi_bus_bridge (32- and 64-bit instances)
module tb_dm_dmi_bus_bridge;
  import dm_dmi_bus_bridge_pkg::*;

  localparam int TO = 8;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } ret_t;

  logic clk;
  logic rst_ni;
  int   cyc = 0;
  bit   chk_en = 0;
  int   checks = 0;
  int   failures = 0;

  dm_dmi_bus_bridge_if #(.BusWidth(32)) b32 ();
  dm_dmi_bus_bridge_if #(.BusWidth(64)) b64 ();

  logic      d32_req_valid, d32_req_ready, d32_resp_valid, d32_resp_ready;
  dmi_req_t  d32_req;
  dmi_resp_t d32_resp;
  logic      d64_req_valid, d64_req_ready, d64_resp_valid, d64_resp_ready;
  dmi_req_t  d64_req;
  dmi_resp_t d64_resp;

  dm_dmi_bus_bridge #(.BusWidth(32), .TimeoutCycles(TO)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_ni), .bus(b32),
    .dmi_req_valid_o(d32_req_valid), .dmi_req_ready_i(d32_req_ready), .dmi_req_o(d32_req),
    .dmi_resp_valid_i(d32_resp_valid), .dmi_resp_ready_o(d32_resp_ready), .dmi_resp_i(d32_resp)
  );

  dm_dmi_bus_bridge #(.BusWidth(64), .TimeoutCycles(TO)) u_dut64 (
    .clk_i(clk), .rst_ni(rst_ni), .bus(b64),
    .dmi_req_valid_o(d64_req_valid), .dmi_req_ready_i(d64_req_ready), .dmi_req_o(d64_req),
    .dmi_resp_valid_i(d64_resp_valid), .dmi_resp_ready_o(d64_resp_ready), .dmi_resp_i(d64_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected per-cycle behaviour, keyed by cycle*2 + instance (0 = 32-bit, 1 = 64-bit)
  bit       exp_gnt[int];
  dmi_req_t exp_req[int];
  ret_t     exp_rv[int];

  dmi_req_t    last_req[2];
  logic [63:0] last_rdata[2];
  logic        last_err[2];
  int          last_rv_cyc[2];
  int          req_cycles[2];
  int          last_t;

  function automatic int key(input int c, input int s);
    return c * 2 + s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Compare both instances against the expectation tables every cycle once out of reset
  always @(negedge clk) begin : cmp
    logic        g, qv, rv, er;
    dmi_req_t    q;
    logic [63:0] rd;
    int          k;
    if (chk_en) begin
      for (int s = 0; s < 2; s++) begin
        if (s == 0) begin
          g = b32.gnt; qv = d32_req_valid; q = d32_req; rv = b32.rvalid; er = b32.err; rd = {32'h0, b32.rdata};
        end else begin
          g = b64.gnt; qv = d64_req_valid; q = d64_req; rv = b64.rvalid; er = b64.err; rd = b64.rdata;
        end
        k = key(cyc, s);
        chk(s ? "gnt64" : "gnt32", {63'h0, g}, {63'h0, exp_gnt.exists(k)});
        chk(s ? "req_valid64" : "req_valid32", {63'h0, qv}, {63'h0, exp_req.exists(k)});
        if (exp_req.exists(k)) chk(s ? "dmi_req64" : "dmi_req32", {23'h0, q}, {23'h0, exp_req[k]});
        chk(s ? "rvalid64" : "rvalid32", {63'h0, rv}, {63'h0, exp_rv.exists(k)});
        if (exp_rv.exists(k)) begin
          chk(s ? "rdata64" : "rdata32", rd, exp_rv[k].rdata);
          chk(s ? "err64" : "err32", {63'h0, er}, {63'h0, exp_rv[k].err});
        end
        if (qv) begin
          last_req[s] = q;
          req_cycles[s]++;
        end
        if (rv) begin
          last_rdata[s]  = rd;
          last_err[s]    = er;
          last_rv_cyc[s] = cyc;
        end
      end
    end
  end

  task automatic drive(input bit s, input bit rq, input bit we, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [7:0] be, input bit rdy,
                       input bit rv, input dmi_resp_t rsp);
    if (!s) begin
      b32.req = rq; b32.we = we; b32.addr = addr[31:0]; b32.wdata = wdata[31:0]; b32.be = be[3:0];
      d32_req_ready = rdy; d32_resp_valid = rv; d32_resp = rsp;
    end else begin
      b64.req = rq; b64.we = we; b64.addr = addr; b64.wdata = wdata; b64.be = be;
      d64_req_ready = rdy; d64_resp_valid = rv; d64_resp = rsp;
    end
  endtask

  // One bus access plus the DM side: stall cycles of ready low, response delay inside RESP,
  // optional no response, optional stale response pulse at cycle t+stale_off
  task automatic access(input bit s, input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] be, input int stall, input int delay, input bit no_resp,
                        input logic [31:0] dm_data, input logic [1:0] dm_resp, input int stale_off);
    int t, h, r, endc;
    ret_t e;
    dmi_req_t q;
    logic [31:0] lw;
    logic [3:0] lb;
    dmi_resp_t rsp;
    bit lane;
    t = cyc;
    last_t = t;
    h = -10;
    r = -10;
    lane = s && addr[2];
    lw = lane ? wdata[63:32] : wdata[31:0];
    lb = lane ? be[7:4] : be[3:0];
    exp_gnt[key(t, s)] = 1'b1;
    if (we && lb != 4'hF) begin
      e.rdata = 64'h0; e.err = 1'b1; endc = t + 1;
    end else begin
      q.addr = addr[8:2];
      q.op   = we ? DTM_WRITE : DTM_READ;
      q.data = we ? lw : 32'h0;
      for (int c = t + 1; c <= t + 1 + stall; c++) exp_req[key(c, s)] = q;
      h = t + 1 + stall;
      if (no_resp) begin
        endc = h + TO + 1; e.rdata = 64'h0; e.err = 1'b1;
      end else begin
        r = h + 1 + delay;
        endc = r + 1;
        e.err = (dm_resp != 2'b00);
        e.rdata = e.err ? 64'h0 : (s ? {dm_data, dm_data} : {32'h0, dm_data});
      end
    end
    exp_rv[key(endc, s)] = e;
    for (int c = t; c <= endc; c++) begin
      rsp.data = (c == r) ? dm_data : 32'hBAD0BAD0;
      rsp.resp = (c == r) ? dm_resp : 2'b00;
      drive(s, c == t, we, addr, wdata, be, c == h,
            (c == r) || (stale_off >= 0 && c == t + stale_off), rsp);
      @(posedge clk); #1;
    end
    drive(s, 0, 0, 64'h0, 64'h0, 8'h0, 0, 0, '0);
  endtask

  initial begin
    int rc;
    dmi_req_t q;
    rst_ni = 1'b0;
    drive(0, 0, 0, 64'h0, 64'h0, 8'h0, 0, 0, '0);
    drive(1, 0, 0, 64'h0, 64'h0, 8'h0, 0, 0, '0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state32", {57'h0, b32.gnt, b32.rvalid, b32.err, d32_req_valid, d32_resp_ready, |b32.rdata, |d32_req}, 64'h0);
    chk("rst_state64", {57'h0, b64.gnt, b64.rvalid, b64.err, d64_req_valid, d64_resp_ready, |b64.rdata, |d64_req}, 64'h0);
    rst_ni = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // dmstatus read, no stall, 1-cycle response
    access(0, 0, 64'h44, 64'h0, 8'hF, 0, 0, 0, 32'h00400C82, 2'd0, -1);
    chk("rd_dmi_req", {23'h0, last_req[0]}, {23'h0, 7'h11, 2'd1, 32'h0});
    chk("rd_rdata", last_rdata[0], 64'h00400C82);
    chk("rd_latency", 64'(last_rv_cyc[0] - last_t), 64'd3);

    // full-word write
    access(0, 1, 64'h40, 64'h1, 8'hF, 0, 0, 0, 32'h0, 2'd0, -1);
    chk("wr_dmi_req", {23'h0, last_req[0]}, {23'h0, 7'h10, 2'd2, 32'h1});
    chk("wr_err", {63'h0, last_err[0]}, 64'h0);

    // partial write fails locally without a DMI request
    rc = req_cycles[0];
    access(0, 1, 64'h40, 64'h5, 8'h3, 0, 0, 0, 32'h0, 2'd0, -1);
    chk("pw_no_req", 64'(req_cycles[0] - rc), 64'h0);
    chk("pw_err", {63'h0, last_err[0]}, 64'h1);
    chk("pw_latency", 64'(last_rv_cyc[0] - last_t), 64'd1);

    // DM error response
    access(0, 0, 64'h48, 64'h0, 8'hF, 0, 1, 0, 32'h12341234, 2'd2, -1);

    // 50 cycles of request backpressure: payload held, no timeout
    rc = req_cycles[0];
    access(0, 1, 64'h10, 64'hA5A55A5A, 8'hF, 50, 0, 0, 32'h0, 2'd0, -1);
    chk("stall_req_cycles", 64'(req_cycles[0] - rc), 64'd51);
    chk("stall_latency", 64'(last_rv_cyc[0] - last_t), 64'd53);

    // no response: timeout error, then drain is pending
    access(0, 0, 64'h44, 64'h0, 8'hF, 0, 0, 1, 32'h0, 2'd0, -1);
    chk("to_latency", 64'(last_rv_cyc[0] - last_t), 64'd10);
    chk("to_err", {63'h0, last_err[0]}, 64'h1);
    chk("drain_ready", {63'h0, d32_resp_ready}, 64'h1);

    // late response arrives in the next access's RESP and must be dropped
    access(0, 0, 64'h4, 64'h0, 8'hF, 0, 2, 0, 32'h11112222, 2'd0, 2);
    chk("drain_rdata", last_rdata[0], 64'h11112222);
    chk("drain_cleared", {63'h0, d32_resp_ready}, 64'h0);

    // response on the last timer cycle wins over the timeout
    access(0, 0, 64'h8, 64'h0, 8'hF, 0, TO - 1, 0, 32'h00000007, 2'd0, -1);
    chk("race_latency", 64'(last_rv_cyc[0] - last_t), 64'd10);
    chk("race_err", {63'h0, last_err[0]}, 64'h0);
    chk("race_no_drain", {63'h0, d32_resp_ready}, 64'h0);

    // 64-bit bus: read replicated to both halves, upper-lane write, upper-lane partial write
    access(1, 0, 64'h4C, 64'h0, 8'hFF, 0, 0, 0, 32'h12345678, 2'd0, -1);
    chk("rd64_dmi_req", {23'h0, last_req[1]}, {23'h0, 7'h13, 2'd1, 32'h0});
    chk("rd64_rdata", last_rdata[1], 64'h12345678_12345678);
    access(1, 1, 64'h44, 64'hCAFEF00D_11111111, 8'hF0, 0, 0, 0, 32'h0, 2'd0, -1);
    chk("wr64_dmi_req", {23'h0, last_req[1]}, {23'h0, 7'h11, 2'd2, 32'hCAFEF00D});
    access(1, 1, 64'h44, 64'hCAFEF00D_11111111, 8'h0F, 0, 0, 0, 32'h0, 2'd0, -1);
    chk("pw64_err", {63'h0, last_err[1]}, 64'h1);

    // reset while waiting in RESP: no rvalid, bridge idle afterwards
    last_t = cyc;
    q.addr = 7'h12; q.op = DTM_READ; q.data = 32'h0;
    exp_gnt[key(last_t, 0)] = 1'b1;
    exp_req[key(last_t + 1, 0)] = q;
    drive(0, 1, 0, 64'h48, 64'h0, 8'hF, 0, 0, '0);
    @(posedge clk); #1;
    drive(0, 0, 0, 64'h0, 64'h0, 8'h0, 1, 0, '0);
    @(posedge clk); #1;
    drive(0, 0, 0, 64'h0, 64'h0, 8'h0, 0, 0, '0);
    @(posedge clk); #1;
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    chk("mid_rst_idle", {62'h0, d32_resp_ready, d32_req_valid}, 64'h0);
    repeat (12) @(posedge clk);
    #1;
    access(0, 0, 64'h44, 64'h0, 8'hF, 0, 0, 0, 32'h0BADF00D, 2'd0, -1);
    chk("post_rst_rdata", last_rdata[0], 64'h0BADF00D);

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
